// File: rtl/riscv_cache_tag_hs_if.sv
// Handshake bus of the cache tag stage.
//  Upstream   : flush_i, req_i/rdy_o, phys_adr_i, size_i, lock_i, prot_i, we_i,
//               cacheflush_i, pagefault_i, d_i
//  Downstream : req_o/rdy_i, wreq_o, adr_o, size_o, lock_o, prot_o, we_o,
//               cacheflush_o, pagefault_o, be_o, q_o, misaligned_o
//  slave  : the tag stage view
//  master : the environment (setup stage + hit/miss stage) view
// size codes: 0 BYTE, 1 HWORD, 2 WORD, 3 DWORD, others illegal.
interface riscv_cache_tag_hs_if #(
  parameter int XLEN = 32,
  parameter int PLEN = XLEN
);
  logic              flush_i;
  logic              req_i;
  logic              rdy_o;
  logic [PLEN-1:0]   phys_adr_i;
  logic [2:0]        size_i;
  logic              lock_i;
  logic [2:0]        prot_i;
  logic              we_i;
  logic              cacheflush_i;
  logic              pagefault_i;
  logic [XLEN-1:0]   d_i;

  logic              req_o;
  logic              rdy_i;
  logic              wreq_o;
  logic [PLEN-1:0]   adr_o;
  logic [2:0]        size_o;
  logic              lock_o;
  logic [2:0]        prot_o;
  logic              we_o;
  logic              cacheflush_o;
  logic              pagefault_o;
  logic [XLEN/8-1:0] be_o;
  logic [XLEN-1:0]   q_o;
  logic              misaligned_o;

  modport slave (
    input  flush_i, req_i, phys_adr_i, size_i, lock_i, prot_i, we_i,
           cacheflush_i, pagefault_i, d_i, rdy_i,
    output rdy_o, req_o, wreq_o, adr_o, size_o, lock_o, prot_o, we_o,
           cacheflush_o, pagefault_o, be_o, q_o, misaligned_o
  );

  modport master (
    output flush_i, req_i, phys_adr_i, size_i, lock_i, prot_i, we_i,
           cacheflush_i, pagefault_i, d_i, rdy_i,
    input  rdy_o, req_o, wreq_o, adr_o, size_o, lock_o, prot_o, we_o,
           cacheflush_o, pagefault_o, be_o, q_o, misaligned_o
  );
endinterface

// File: rtl/riscv_cache_tag_hs.sv
// Cache tag stage with valid/ready handshake.
//  Registers the core request for one cycle while tag/data RAMs are read and
//  produces byte enables, lane-replicated store data and an alignment error.
//  SKID=1: registered rdy_o and one skid entry (EMPTY/ONE/FULL).
//  SKID=0: rdy_o = rdy_i | ~req_o, no skid entry.
// Ports:
//  clk_i, rst_ni  clock, async active-low reset
//  bus            riscv_cache_tag_hs_if.slave (request in, response out)
//  core_tag_o     tag field of phys_adr_i, combinational for the RAM compare

// One byte lane: byte enable and replicated store byte.
module riscv_cache_tag_hs_lane #(
  parameter int LANE = 0,
  parameter int NB   = 4
) (
  input  logic [2:0]            size_i,
  input  logic [$clog2(NB)-1:0] off_i,
  input  logic                  mis_i,
  input  logic [7:0]            b_byte_i,   // d byte 0
  input  logic [7:0]            b_hword_i,  // d byte LANE%2
  input  logic [7:0]            b_word_i,   // d byte LANE%4
  input  logic [7:0]            b_own_i,    // d byte LANE
  output logic                  be_o,
  output logic [7:0]            q_o
);
  logic [3:0] span;

  always_comb begin
    span = 4'd0;
    q_o  = b_own_i;
    case (size_i)
      3'b000:  begin span = 4'd1; q_o = b_byte_i;  end
      3'b001:  begin span = 4'd2; q_o = b_hword_i; end
      3'b010:  begin span = 4'd4; q_o = b_word_i;  end
      3'b011:  span = 4'd8;
      default: ;
    endcase
    be_o = !mis_i && (LANE >= int'(off_i)) && (LANE < int'(off_i) + int'(span));
  end
endmodule

module riscv_cache_tag_hs #(
  parameter  int XLEN          = 32,
  parameter  int PLEN          = XLEN,
  parameter  int SIZE          = 64,
  parameter  int BLOCK_SIZE    = XLEN,
  parameter  int WAYS          = 2,
  parameter  int SKID          = 1,
  localparam int BLK_OFFS_BITS = $clog2(BLOCK_SIZE/8),
  localparam int IDX_BITS      = $clog2(SIZE*1024/(BLOCK_SIZE/8)/WAYS),
  localparam int TAG_BITS      = PLEN - IDX_BITS - BLK_OFFS_BITS
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  riscv_cache_tag_hs_if.slave bus,
  output logic [TAG_BITS-1:0] core_tag_o
);
  localparam int NB   = XLEN/8;
  localparam int OFFW = $clog2(NB);

  localparam logic [2:0] SZ_BYTE  = 3'b000;
  localparam logic [2:0] SZ_HWORD = 3'b001;
  localparam logic [2:0] SZ_WORD  = 3'b010;
  localparam logic [2:0] SZ_DWORD = 3'b011;

  typedef struct packed {
    logic [PLEN-1:0] adr;
    logic [2:0]      size;
    logic            lock;
    logic [2:0]      prot;
    logic            we;
    logic            cacheflush;
    logic            pagefault;
    logic [NB-1:0]   be;
    logic [XLEN-1:0] q;
    logic            mis;
  } pl_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

  state_t               state, nxt;
  pl_t                  in_pl, out_q, skid_q;
  logic                 mis, rdy, rdy_q, req_o;
  logic                 in_xfer, out_xfer;
  logic                 load_out, load_skid, skid_to_out;
  logic [NB-1:0]        be;
  logic [NB-1:0][7:0]   q;

  assign core_tag_o = bus.phys_adr_i[PLEN-1 -: TAG_BITS];

  // DWORD only exists on a 64-bit datapath; unknown size codes are errors.
  always_comb begin
    mis = 1'b1;
    case (bus.size_i)
      SZ_BYTE:  mis = 1'b0;
      SZ_HWORD: mis = bus.phys_adr_i[0];
      SZ_WORD:  mis = |bus.phys_adr_i[1:0];
      SZ_DWORD: mis = (XLEN == 64) ? |bus.phys_adr_i[2:0] : 1'b1;
      default:  mis = 1'b1;
    endcase
  end

  for (genvar k = 0; k < NB; k++) begin : g_lane
    riscv_cache_tag_hs_lane #(.LANE(k), .NB(NB)) u_lane (
      .size_i    (bus.size_i),
      .off_i     (bus.phys_adr_i[OFFW-1:0]),
      .mis_i     (mis),
      .b_byte_i  (bus.d_i[7:0]),
      .b_hword_i (bus.d_i[8*(k%2) +: 8]),
      .b_word_i  (bus.d_i[8*(k%4) +: 8]),
      .b_own_i   (bus.d_i[8*k +: 8]),
      .be_o      (be[k]),
      .q_o       (q[k])
    );
  end

  always_comb begin
    in_pl.adr        = bus.phys_adr_i;
    in_pl.size       = bus.size_i;
    in_pl.lock       = bus.lock_i;
    in_pl.prot       = bus.prot_i;
    in_pl.we         = bus.we_i;
    in_pl.cacheflush = bus.cacheflush_i;
    in_pl.pagefault  = bus.pagefault_i;
    in_pl.be         = be;
    in_pl.q          = q;
    in_pl.mis        = mis;
  end

  // Handshake
  assign req_o    = (state != ST_EMPTY);
  assign rdy      = (SKID != 0) ? rdy_q : (bus.rdy_i | ~req_o);
  assign in_xfer  = bus.req_i & rdy;
  assign out_xfer = req_o & bus.rdy_i;

  // With SKID=0 rdy already implies the output slot drains, so FULL is unreachable.
  always_comb begin
    nxt         = state;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    case (state)
      ST_EMPTY: if (in_xfer) begin nxt = ST_ONE; load_out = 1'b1; end
      ST_ONE: begin
        if (in_xfer && out_xfer) load_out = 1'b1;
        else if (in_xfer) begin nxt = ST_FULL; load_skid = 1'b1; end
        else if (out_xfer) nxt = ST_EMPTY;
      end
      ST_FULL: if (out_xfer) begin nxt = ST_ONE; skid_to_out = 1'b1; end
      default: nxt = ST_EMPTY;
    endcase
    // flush beats any transfer in the same cycle
    if (bus.flush_i) begin
      nxt         = ST_EMPTY;
      load_out    = 1'b0;
      load_skid   = 1'b0;
      skid_to_out = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_EMPTY;
      rdy_q <= 1'b1;
    end else begin
      state <= nxt;
      rdy_q <= (nxt != ST_FULL);
    end
  end

  // Payload is qualified by state, so it is left unreset.
  always_ff @(posedge clk_i) begin
    if (load_out)         out_q <= in_pl;
    else if (skid_to_out) out_q <= skid_q;
    if (load_skid)        skid_q <= in_pl;
  end

  assign bus.rdy_o        = rdy;
  assign bus.req_o        = req_o;
  assign bus.wreq_o       = req_o & out_q.we & ~out_q.mis & ~out_q.pagefault;
  assign bus.adr_o        = out_q.adr;
  assign bus.size_o       = out_q.size;
  assign bus.lock_o       = out_q.lock;
  assign bus.prot_o       = out_q.prot;
  assign bus.we_o         = out_q.we;
  assign bus.cacheflush_o = out_q.cacheflush;
  assign bus.pagefault_o  = out_q.pagefault;
  assign bus.be_o         = out_q.be;
  assign bus.q_o          = out_q.q;
  assign bus.misaligned_o = out_q.mis;
endmodule

// File: tb/tb_riscv_cache_tag_hs.sv
// Bench for riscv_cache_tag_hs: dut_a XLEN=32 SKID=1, dut_b XLEN=64 SKID=0.
// A queue per DUT holds the requests it must be holding; the head is what
// the output must show.
module tb_riscv_cache_tag_hs;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  riscv_cache_tag_hs_if #(.XLEN(32), .PLEN(32)) ifa ();
  riscv_cache_tag_hs_if #(.XLEN(64), .PLEN(64)) ifb ();
  logic [16:0] tag_a;  // 64KB, 2 ways, 4B lines: 13 idx + 2 offs bits
  logic [48:0] tag_b;  // 64KB, 2 ways, 8B lines: 12 idx + 3 offs bits

  riscv_cache_tag_hs #(.XLEN(32), .SKID(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .bus(ifa.slave), .core_tag_o(tag_a));
  riscv_cache_tag_hs #(.XLEN(64), .SKID(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .bus(ifb.slave), .core_tag_o(tag_b));

  int checks = 0;
  int failures = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [63:0] adr;
    logic [2:0]  size;
    logic        lock;
    logic [2:0]  prot;
    logic        we, cf, pf;
    logic [7:0]  be;
    logic [63:0] q;
    logic        mis;
  } exp_t;

  // Expected response from the size/alignment rules.
  function automatic exp_t mk(int xlen, logic [63:0] adr, logic [2:0] size,
                              logic [63:0] d, logic we, logic pf, logic lock,
                              logic [2:0] prot, logic cf);
    exp_t e;
    int nb, n, unit, off;
    nb = xlen / 8;
    off = int'(adr[2:0]) % nb;
    case (size)
      3'd0: n = 1;
      3'd1: n = 2;
      3'd2: n = 4;
      3'd3: n = 8;
      default: n = 0;
    endcase
    if (n == 0 || n > nb) e.mis = 1'b1;
    else e.mis = (int'(adr[3:0]) % n) != 0;
    e.be = '0;
    if (!e.mis)
      for (int k = 0; k < nb; k++) if (k >= off && k < off + n) e.be[k] = 1'b1;
    unit = (n != 0 && n < nb) ? n : nb;
    e.q = '0;
    for (int k = 0; k < nb; k++) e.q[8*k +: 8] = d[8*(k % unit) +: 8];
    e.adr = adr; e.size = size; e.lock = lock; e.prot = prot;
    e.we = we; e.cf = cf; e.pf = pf;
    return e;
  endfunction

  exp_t qa[$];
  exp_t qb[$];
  bit pa, ua, pb, ub;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
    end else begin
      if (ifa.flush_i) qa.delete();
      else begin
        ua = qa.size() != 0 && ifa.rdy_i;
        pa = ifa.req_i && qa.size() < 2;
        if (ua) void'(qa.pop_front());
        if (pa) qa.push_back(mk(32, 64'(ifa.phys_adr_i), ifa.size_i, 64'(ifa.d_i),
                                ifa.we_i, ifa.pagefault_i, ifa.lock_i, ifa.prot_i,
                                ifa.cacheflush_i));
      end
      if (ifb.flush_i) qb.delete();
      else begin
        ub = qb.size() != 0 && ifb.rdy_i;
        pb = ifb.req_i && (ifb.rdy_i || qb.size() == 0);
        if (ub) void'(qb.pop_front());
        if (pb) qb.push_back(mk(64, ifb.phys_adr_i, ifb.size_i, ifb.d_i,
                                ifb.we_i, ifb.pagefault_i, ifb.lock_i, ifb.prot_i,
                                ifb.cacheflush_i));
      end
    end
  end

  task automatic cmp_a(exp_t e);
    chk("a_adr",  64'(ifa.adr_o), e.adr);
    chk("a_size", 64'(ifa.size_o), 64'(e.size));
    chk("a_lock", 64'(ifa.lock_o), 64'(e.lock));
    chk("a_prot", 64'(ifa.prot_o), 64'(e.prot));
    chk("a_we",   64'(ifa.we_o), 64'(e.we));
    chk("a_cf",   64'(ifa.cacheflush_o), 64'(e.cf));
    chk("a_pf",   64'(ifa.pagefault_o), 64'(e.pf));
    chk("a_be",   64'(ifa.be_o), 64'(e.be));
    chk("a_q",    64'(ifa.q_o), e.q);
    chk("a_mis",  64'(ifa.misaligned_o), 64'(e.mis));
    chk("a_wreq", 64'(ifa.wreq_o), 64'(e.we & ~e.mis & ~e.pf));
  endtask

  task automatic cmp_b(exp_t e);
    chk("b_adr",  ifb.adr_o, e.adr);
    chk("b_size", 64'(ifb.size_o), 64'(e.size));
    chk("b_lock", 64'(ifb.lock_o), 64'(e.lock));
    chk("b_prot", 64'(ifb.prot_o), 64'(e.prot));
    chk("b_we",   64'(ifb.we_o), 64'(e.we));
    chk("b_cf",   64'(ifb.cacheflush_o), 64'(e.cf));
    chk("b_pf",   64'(ifb.pagefault_o), 64'(e.pf));
    chk("b_be",   64'(ifb.be_o), 64'(e.be));
    chk("b_q",    ifb.q_o, e.q);
    chk("b_mis",  64'(ifb.misaligned_o), 64'(e.mis));
    chk("b_wreq", 64'(ifb.wreq_o), 64'(e.we & ~e.mis & ~e.pf));
  endtask

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    chk("a_req", 64'(ifa.req_o), 64'(qa.size() != 0));
    chk("a_rdy", 64'(ifa.rdy_o), 64'(qa.size() < 2));
    chk("a_tag", 64'(tag_a), 64'(ifa.phys_adr_i >> 15));
    if (qa.size() != 0) cmp_a(qa[0]);
    else chk("a_wreq_idle", 64'(ifa.wreq_o), 64'(0));
    chk("b_req", 64'(ifb.req_o), 64'(qb.size() != 0));
    chk("b_rdy", 64'(ifb.rdy_o), 64'(ifb.rdy_i || qb.size() == 0));
    chk("b_tag", 64'(tag_b), ifb.phys_adr_i >> 15);
    if (qb.size() != 0) cmp_b(qb[0]);
    else chk("b_wreq_idle", 64'(ifb.wreq_o), 64'(0));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(bit req, logic [31:0] adr, logic [2:0] sz, bit we,
                       logic [31:0] d, bit pf, bit rdy);
    ifa.req_i = req; ifa.phys_adr_i = adr; ifa.size_i = sz; ifa.we_i = we;
    ifa.d_i = d; ifa.pagefault_i = pf; ifa.rdy_i = rdy;
    ifa.lock_i = adr[8]; ifa.prot_i = adr[10:8]; ifa.cacheflush_i = adr[12];
  endtask

  task automatic drv_b(bit req, logic [63:0] adr, logic [2:0] sz, bit we,
                       logic [63:0] d, bit pf, bit rdy);
    ifb.req_i = req; ifb.phys_adr_i = adr; ifb.size_i = sz; ifb.we_i = we;
    ifb.d_i = d; ifb.pagefault_i = pf; ifb.rdy_i = rdy;
    ifb.lock_i = adr[8]; ifb.prot_i = adr[10:8]; ifb.cacheflush_i = adr[12];
  endtask

  // extra XLEN=32 vectors, streamed with rdy_i=1
  logic [31:0] va_adr[6] = '{32'h2002, 32'h3001, 32'h4000, 32'h5000, 32'h6000, 32'h7001};
  logic [2:0]  va_sz[6]  = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd6, 3'd0};
  logic [31:0] va_d[6]   = '{32'hBEEF, 32'h01020304, 32'hDEADBEEF, 32'h55AA55AA, 32'h77, 32'h11};
  bit          va_we[6]  = '{1, 1, 1, 0, 1, 0};
  bit          va_pf[6]  = '{0, 0, 1, 0, 0, 0};

  // extra XLEN=64 vectors
  logic [63:0] vb_adr[4] = '{64'h0000_0040_0000_2008, 64'h0000_0040_0000_3005,
                             64'h0000_0040_0000_4004, 64'h0000_0040_0000_5000};
  logic [2:0]  vb_sz[4]  = '{3'd3, 3'd0, 3'd3, 3'd5};
  logic [63:0] vb_d[4]   = '{64'h1122334455667788, 64'h3C, 64'hCAFEF00D, 64'h9};

  initial begin
    ifa.flush_i = 1'b0;
    ifb.flush_i = 1'b0;
    drv_a(0, 32'h0, 3'd0, 0, 32'h0, 0, 1);
    drv_b(0, 64'h0, 3'd0, 0, 64'h0, 0, 1);
    #1 rst_n = 1'b0;
    #11;
    chk("rst_a_req", 64'(ifa.req_o), 64'(0));
    chk("rst_a_wreq", 64'(ifa.wreq_o), 64'(0));
    chk("rst_a_rdy", 64'(ifa.rdy_o), 64'(1));
    chk("rst_b_req", 64'(ifb.req_o), 64'(0));
    chk("rst_b_rdy", 64'(ifb.rdy_o), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // XLEN=32 byte store at 0x1003
    step();
    drv_a(1, 32'h1003, 3'd0, 1, 32'hA5, 0, 1);
    step();
    chk("t1_req",  64'(ifa.req_o), 64'(1));
    chk("t1_wreq", 64'(ifa.wreq_o), 64'(1));
    chk("t1_be",   64'(ifa.be_o), 64'(4'b1000));
    chk("t1_q",    64'(ifa.q_o), 64'(32'hA5A5A5A5));
    chk("t1_mis",  64'(ifa.misaligned_o), 64'(0));
    for (int i = 0; i < 6; i++) begin
      drv_a(1, va_adr[i], va_sz[i], va_we[i], va_d[i], va_pf[i], 1);
      step();
    end
    chk("t1_hw_pin", 64'(mk(32, 64'h2002, 3'd1, 64'hBEEF, 1, 0, 0, 3'd0, 0).q),
        64'(32'hBEEFBEEF));
    drv_a(0, 32'h0, 3'd0, 0, 32'h0, 0, 1);
    step();
    step();

    // XLEN=64: word at ...4, then misaligned half-word at ...3
    drv_b(1, 64'h8000_0000_0000_1004, 3'd2, 1, 64'h12345678, 0, 1);
    step();
    chk("t2_be",  64'(ifb.be_o), 64'(8'hF0));
    chk("t2_q",   ifb.q_o, 64'h1234567812345678);
    chk("t2_wreq", 64'(ifb.wreq_o), 64'(1));
    drv_b(1, 64'h8000_0000_0000_1003, 3'd1, 1, 64'hABCD, 0, 1);
    step();
    chk("t2_mis",  64'(ifb.misaligned_o), 64'(1));
    chk("t2_be0",  64'(ifb.be_o), 64'(0));
    chk("t2_wreq0", 64'(ifb.wreq_o), 64'(0));
    for (int i = 0; i < 4; i++) begin
      drv_b(1, vb_adr[i], vb_sz[i], 1, vb_d[i], 0, 1);
      step();
      if (i == 1) chk("t2_byte_be", 64'(ifb.be_o), 64'(8'h20));
    end
    drv_b(0, 64'h0, 3'd0, 0, 64'h0, 0, 1);
    step();

    // SKID=0: combinational rdy_o
    drv_b(1, 64'h100, 3'd2, 0, 64'h1, 0, 0);
    step();
    drv_b(1, 64'h108, 3'd2, 0, 64'h2, 0, 0);
    #1 chk("t5_rdy_lo", 64'(ifb.rdy_o), 64'(0));
    ifb.rdy_i = 1'b1;
    #1 chk("t5_rdy_hi", 64'(ifb.rdy_o), 64'(1));
    step();
    chk("t5_d2", ifb.adr_o, 64'h108);
    drv_b(1, 64'h110, 3'd2, 0, 64'h3, 0, 1);
    step();
    chk("t5_d3", ifb.adr_o, 64'h110);
    drv_b(0, 64'h0, 3'd0, 0, 64'h0, 0, 1);
    step();
    chk("t5_idle", 64'(ifb.req_o), 64'(0));

    // SKID=1 backpressure: A, B, C
    drv_a(1, 32'h100, 3'd2, 0, 32'hA, 0, 0);
    step();
    chk("t3_a", 64'(ifa.adr_o), 64'(32'h100));
    drv_a(1, 32'h104, 3'd2, 0, 32'hB, 0, 0);
    step();
    chk("t3_full_rdy", 64'(ifa.rdy_o), 64'(0));
    drv_a(1, 32'h108, 3'd2, 0, 32'hC, 0, 0);
    step();
    chk("t3_hold_a", 64'(ifa.adr_o), 64'(32'h100));
    ifa.rdy_i = 1'b1;
    step();
    chk("t3_b", 64'(ifa.adr_o), 64'(32'h104));
    step();
    chk("t3_c", 64'(ifa.adr_o), 64'(32'h108));
    drv_a(0, 32'h0, 3'd0, 0, 32'h0, 0, 1);
    step();
    chk("t3_done", 64'(ifa.req_o), 64'(0));

    // flush while FULL, request presented and rdy_i high
    drv_a(1, 32'h800, 3'd2, 1, 32'h1, 0, 0);
    step();
    drv_a(1, 32'h804, 3'd2, 1, 32'h2, 0, 0);
    step();
    drv_a(1, 32'h808, 3'd2, 1, 32'h3, 0, 1);
    ifa.flush_i = 1'b1;
    step();
    ifa.flush_i = 1'b0;
    drv_a(0, 32'h0, 3'd0, 0, 32'h0, 0, 1);
    chk("t4_req", 64'(ifa.req_o), 64'(0));
    chk("t4_rdy", 64'(ifa.rdy_o), 64'(1));
    repeat (3) step();

    // async reset while FULL
    drv_a(1, 32'h900, 3'd2, 1, 32'h1, 0, 0);
    step();
    drv_a(1, 32'h904, 3'd2, 1, 32'h2, 0, 0);
    step();
    drv_a(0, 32'h0, 3'd0, 0, 32'h0, 0, 0);
    chk("t6_pre_wreq", 64'(ifa.wreq_o), 64'(1));
    chk("t6_pre_rdy", 64'(ifa.rdy_o), 64'(0));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req",  64'(ifa.req_o), 64'(0));
    chk("t6_wreq", 64'(ifa.wreq_o), 64'(0));
    chk("t6_rdy",  64'(ifa.rdy_o), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    ifa.rdy_i = 1'b1;
    step();
    chk("t6_after", 64'(ifa.req_o), 64'(0));
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
